// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the pipeline. Owns the PC, drives the combinational
// instruction memory, and queues fetched words in a small prefetch FIFO.
// Decode (IF/ID) reads the FIFO head through a valid/stall handshake.
// A branch or jump redirect flushes the FIFO and reloads the PC.
//
// Parameters
//   RESET_PC : PC loaded on reset (word-aligned byte address)
//   DEPTH    : prefetch FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   imem_addr / imem_instr: instruction memory request (= PC) / returned word
//   redirect_valid/_pc    : taken branch/jump and its target byte address
//   stall                 : decode cannot accept the head entry this cycle
//   ifid_valid/_instr/_pc/_pc_plus4 : FIFO head presented to decode
//   fetch_fault           : sticky misaligned-redirect fault
//
// Build option
//   IFU_MISALIGN_TRAP_EN : when defined, a redirect to a non-word-aligned
//   target sets fetch_fault and halts fetch until reset. When undefined, the
//   low two target bits are dropped and fetch_fault is tied low.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is never reset: count_q alone decides whether an entry is live.
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];

  logic        push, pop, halted;
  logic [31:0] redirect_tgt;

`ifdef IFU_MISALIGN_TRAP_EN
  // Halt and fault are the same sticky state: a misaligned redirect stops
  // fetch and raises the fault until reset.
  logic fault_q, fault_d;
  assign halted       = fault_q;
  assign fetch_fault  = fault_q;
  assign redirect_tgt = redirect_pc;
`else
  assign halted       = 1'b0;
  assign fetch_fault  = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_addr = pc_q;
  assign ifid_valid = (count_q != '0);
  assign pop  = ifid_valid & ~stall & ~redirect_valid;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign push = ~redirect_valid & ~halted & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    if (redirect_valid) begin
      // Redirect wins over everything: drop all prefetched words.
      pc_d     = redirect_tgt;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
`endif
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q  <= fault_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= pc_q;
      fifo_instr[wr_ptr_q] <= imem_instr;
    end
  end

  // Head outputs read zero whenever the FIFO is empty.
  assign ifid_pc       = ifid_valid ? fifo_pc[rd_ptr_q]           : 32'h0;
  assign ifid_instr    = ifid_valid ? fifo_instr[rd_ptr_q]        : 32'h0;
  assign ifid_pc_plus4 = ifid_valid ? fifo_pc[rd_ptr_q] + 32'd4   : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, stall;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_instr;
  logic        ifid_valid, fetch_fault;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;

  logic [31:0] imem_addr2, imem_instr2;
  logic        ifid_valid2, fetch_fault2;
  logic [31:0] ifid_instr2, ifid_pc2, ifid_pc_plus4_2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Memory model: distinctive word derived from the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_instr  = mem(imem_addr);
  assign imem_instr2 = mem(imem_addr2);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .stall(1'b0),
    .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
    .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus4_2),
    .fetch_fault(fetch_fault2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, ifid_valid}, 32'h1);
    check({tag, "_pc"},    ifid_pc, pc);
    check({tag, "_instr"}, ifid_instr, mem(pc));
    check({tag, "_pc4"},   ifid_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    // Reset state
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pc",    ifid_pc, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4",   ifid_pc_plus4, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

    // Release: first valid one edge later, then one word per cycle
    rst_n = 1'b1;
    check("rel_valid0", {31'b0, ifid_valid}, 32'h0);
    step();
    head("s0", 32'h0);
    check("s0_addr", imem_addr, 32'h4);
    check("w0_pc",   ifid_pc2, 32'hFFFF_FFFC);
    check("w0_pc4",  ifid_pc_plus4_2, 32'h0);
    step();
    head("s1", 32'h4);
    check("w1_pc",   ifid_pc2, 32'h0);
    check("w1_valid", {31'b0, ifid_valid2}, 32'h1);
    step();
    head("s2", 32'h8);
    check("s2_addr", imem_addr, 32'hC);

    // Stall with head at 0x8: FIFO fills, PC freezes at 0x10
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc",   ifid_pc, 32'h8);
      check("stall_addr", imem_addr, 32'h10);
    end
    stall = 1'b0;
    #1;
    head("rel0", 32'h8);
    step();
    head("rel1", 32'hC);
    step();
    head("rel2", 32'h10);

    // Redirect while stalled and full
    stall = 1'b1;
    step();
    check("full_pc",   ifid_pc, 32'h10);
    check("full_addr", imem_addr, 32'h18);
    redirect_valid = 1'b1; redirect_pc = 32'h38;
    step();
    redirect_valid = 1'b0;
    check("rd_valid", {31'b0, ifid_valid}, 32'h0);
    check("rd_addr",  imem_addr, 32'h38);
    check("rd_pc0",   ifid_pc, 32'h0);
    step();
    head("rd_tgt", 32'h38);
    stall = 1'b0;

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("b2b_valid", {31'b0, ifid_valid}, 32'h0);
    check("b2b_addr",  imem_addr, 32'h200);
    step();
    head("b2b_tgt", 32'h200);
    step();
    head("b2b_nxt", 32'h204);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h3A;
    step();
    redirect_valid = 1'b0;
    check("mis_valid", {31'b0, ifid_valid}, 32'h0);
`ifdef IFU_MISALIGN_TRAP_EN
    check("mis_addr",  imem_addr, 32'h3A);
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_hold_valid", {31'b0, ifid_valid}, 32'h0);
      check("mis_hold_fault", {31'b0, fetch_fault}, 32'h1);
      check("mis_hold_addr",  imem_addr, 32'h3A);
    end
`else
    check("mis_addr",  imem_addr, 32'h38);
    check("mis_fault", {31'b0, fetch_fault}, 32'h0);
    step();
    head("mis_tgt", 32'h38);
    step();
    head("mis_nxt", 32'h3C);
`endif

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, ifid_valid}, 32'h0);
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_fault", {31'b0, fetch_fault}, 32'h0);
    check("arst_addr2", imem_addr2, 32'hFFFF_FFFC);
    check("arst_v2",    {31'b0, ifid_valid2}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    head("arst_s0", 32'h0);
    step();
    head("arst_s1", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard bound in case the stimulus ever stalls on an event.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
